// File: rtl/mem_client_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mem_client_rsp_fifo
//  Purpose  : Small synchronous response FIFO for mem_client. Holds read data
//             captured from the memory until the requester accepts it. The
//             head entry is presented straight from the storage registers, so
//             it stays stable until it is popped.
//  Ports    : clock      - single clock, posedge
//             reset_n    - asynchronous active-low reset
//             push       - write push_data into the tail entry
//             push_data  - data to store
//             pop        - retire the head entry (ignored when empty)
//             occupancy  - number of valid entries (0..DEPTH)
//             head       - data of the oldest entry (0 after reset)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_client_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [WIDTH-1:0]             head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (occupancy != '0);
    assign head   = store[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_client.sv
`default_nettype none
// ============================================================================
//  Module   : mem_client
//  Purpose  : Requester-side port controller for the single-read/single-write
//             port `mem` block. Write requests pass straight through to the
//             write port and never stall. Read requests are issued to the read
//             port, the one-cycle read latency is tracked with `pending`, and
//             returned words are buffered in a RSP_DEPTH-entry FIFO behind a
//             back-pressurable response channel. A credit check on rd_ready
//             guarantees the FIFO can never overflow.
//  Macro    : MEM_CLIENT_WR_BYPASS_EN - when defined, a read and write that
//             fire together on the same address return the NEW word; when
//             undefined the response is the old word read from the memory.
//  Ports    : clock, reset_n                     - clock / async active-low reset
//             wr_valid, wr_ready, wr_addr, wr_data - write request channel
//             rd_valid, rd_ready, rd_addr         - read request channel
//             rsp_valid, rsp_ready, rsp_data      - read response channel
//             mem_data, mem_wraddress, mem_wren   - to memory write port
//             mem_rdaddress, mem_rden, mem_q      - memory read port
//  Revision : 1.0 - initial release
// ============================================================================
module mem_client #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 64,
    parameter  int RSP_DEPTH = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] mem_data,
    output logic [AW-1:0]    mem_wraddress,
    output logic             mem_wren,
    output logic [AW-1:0]    mem_rdaddress,
    output logic             mem_rden,
    input  logic [WIDTH-1:0] mem_q
);

    localparam int OCC_W = $clog2(RSP_DEPTH + 1);

    logic             active;     // low in reset, high from the first edge after release
    logic             pending;    // a read was issued last cycle; mem_q is valid now
    logic [OCC_W-1:0] occupancy;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic [OCC_W:0]   committed;  // entries owed to the FIFO after this cycle's pop

    // Write path: pure pass-through, stalls only during reset.
    assign wr_ready      = active;
    assign mem_wren      = wr_valid & wr_ready;
    assign mem_wraddress = wr_addr;
    assign mem_data      = wr_data;

    // Read issue.
    assign mem_rden      = rd_valid & rd_ready;
    assign mem_rdaddress = rd_addr;

    // Response channel.
    assign rsp_valid = (occupancy != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Credit: the in-flight read counts against the buffer, a pop this cycle
    // frees a slot early so one read per cycle is sustained when draining.
    assign committed = {1'b0, occupancy}
                     + {{OCC_W{1'b0}}, pending}
                     - {{OCC_W{1'b0}}, pop};
    assign rd_ready  = active && (committed < (OCC_W + 1)'(RSP_DEPTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            pending <= 1'b0;
        end else begin
            active  <= 1'b1;
            pending <= mem_rden;
        end
    end

`ifdef MEM_CLIENT_WR_BYPASS_EN
    // Same-address read/write collision: remember the written word and
    // substitute it for the stale memory output at capture time.
    logic             hit;
    logic [WIDTH-1:0] hit_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit      <= 1'b0;
            hit_data <= '0;
        end else begin
            hit      <= mem_rden & mem_wren & (rd_addr == wr_addr);
            hit_data <= wr_data;
        end
    end

    assign push_data = hit ? hit_data : mem_q;
`else
    assign push_data = mem_q;
`endif

    mem_client_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (pending),
        .push_data (push_data),
        .pop       (pop),
        .occupancy (occupancy),
        .head      (rsp_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_client.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_client
//  Purpose  : Self-checking bench for mem_client. Contains a behavioural model
//             of the attached `mem` block (read-before-write, 1-cycle read
//             latency) and a transaction-level reference: a shadow memory plus
//             a queue of accepted reads with their accept cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_client;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 64;
    localparam int RSP_DEPTH = 2;
    localparam int AW        = 6;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_valid = 1'b0;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] mem_data;
    logic [AW-1:0]    mem_wraddress;
    logic             mem_wren;
    logic [AW-1:0]    mem_rdaddress;
    logic             mem_rden;
    logic [WIDTH-1:0] mem_q = '0;

    always #5 clock = ~clock;

    mem_client #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .mem_data      (mem_data),
        .mem_wraddress (mem_wraddress),
        .mem_wren      (mem_wren),
        .mem_rdaddress (mem_rdaddress),
        .mem_rden      (mem_rden),
        .mem_q         (mem_q)
    );

    // Behavioural `mem`: registered read output, read-before-write on collision.
    logic [WIDTH-1:0] mem_arr [DEPTH] = '{default: '0};
    always @(posedge clock) begin
        if (mem_rden) mem_q <= mem_arr[mem_rdaddress];
        if (mem_wren) mem_arr[mem_wraddress] <= mem_data;
    end

    // Reference model state.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               acc;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               alive = 1'b0;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    int               dut_rd_fires = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, check settled outputs, update the model
    // with what the next posedge will do.
    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                        input logic rv, input logic [AW-1:0] ra, input logic rr);
        logic exp_valid;
        logic exp_pop;
        logic exp_rdy;
        exp_t e;
        @(negedge clock);
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        rsp_ready = rr;
        #1;
        // A response becomes visible two cycles after its read was accepted.
        exp_valid = 1'b0;
        if (exp_q.size() > 0) exp_valid = ((cyc - exp_q[0].acc) >= 2);
        exp_pop = exp_valid & rr;
        exp_rdy = alive && ((exp_q.size() - (exp_pop ? 1 : 0)) < RSP_DEPTH);

        check("wr_ready",  32'(wr_ready),  32'(alive));
        check("rd_ready",  32'(rd_ready),  32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        check("mem_wren",  32'(mem_wren),  32'(wv & alive));
        check("mem_rden",  32'(mem_rden),  32'(rv & exp_rdy));
        if (wv) begin
            check("mem_wraddress", 32'(mem_wraddress), 32'(wa));
            check("mem_data",      32'(mem_data),      32'(wd));
        end
        if (rv) check("mem_rdaddress", 32'(mem_rdaddress), 32'(ra));
        if (rv & rd_ready) dut_rd_fires++;

        if (exp_pop) void'(exp_q.pop_front());
        if (rv & exp_rdy) begin
            e.acc  = cyc;
            e.data = ref_mem[ra];
`ifdef MEM_CLIENT_WR_BYPASS_EN
            if (wv && alive && (wa == ra)) e.data = wd;
`endif
            exp_q.push_back(e);
        end
        if (wv & alive) ref_mem[wa] = wd;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, rr);
    endtask

    initial begin
        int f0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset state, with requests asserted to prove nothing fires.
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_wr_ready",  32'(wr_ready),  32'd0);
        check("rst_rd_ready",  32'(rd_ready),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_mem_wren",  32'(mem_wren),  32'd0);
        check("rst_mem_rden",  32'(mem_rden),  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        alive   = 1'b1;

        // Write then read back the same address.
        step(1'b1, 6'd5, 8'hA5, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 6'd5, 1'b1);
        idle(3, 1'b1);

        // Preload 0..7, then 8 back-to-back reads with the consumer always ready.
        for (int i = 0; i < 8; i++) step(1'b1, AW'(i), WIDTH'(8'h10 + i), 1'b0, '0, 1'b1);
        f0 = dut_rd_fires;
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, AW'(i), 1'b1);
        check("b2b_accepts", 32'(dut_rd_fires - f0), 32'd8);
        idle(3, 1'b1);

        // Consumer stalled: only RSP_DEPTH reads get in.
        f0 = dut_rd_fires;
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
        check("stall_accepts", 32'(dut_rd_fires - f0), 32'(RSP_DEPTH));
        idle(4, 1'b1);

        // Same-address read and write in one cycle.
        step(1'b1, 6'd9, 8'h33, 1'b0, '0, 1'b1);
        step(1'b1, 6'd9, 8'h77, 1'b1, 6'd9, 1'b1);
        idle(3, 1'b1);

        // Park one response, then push and pop together for 20 cycles.
        step(1'b0, '0, '0, 1'b1, 6'd3, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), WIDTH'($urandom),
                 1'b1, AW'($urandom_range(0, 7)), 1'b1);
        idle(3, 1'b1);

        // Random traffic on a small address range to provoke collisions.
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), WIDTH'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));
        idle(4, 1'b1);

        // Reset with one response buffered and one read in flight.
        step(1'b0, '0, '0, 1'b1, 6'd1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 6'd2, 1'b0);
        @(negedge clock);
        #1;
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rd_ready",  32'(rd_ready),  32'd0);
        check("mid_rst_rsp_data",  32'(rsp_data),  32'd0);
        exp_q.delete();
        alive = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        alive   = 1'b1;
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
